// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared response codes and responder FSM states
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        R_WAIT,
        R_RESP,
        W_DATA,
        W_WAIT,
        B_RESP
    } state_t;

endpackage

// File: rtl/sram_bytewise.sv
// rtl/sram_bytewise.sv - single-port synchronous word RAM with byte write enables
module sram_bytewise #(
    parameter int DEPTH = 65536,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    we,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane writes plus a registered read of the same address every cycle
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/axil_sram_responder.sv
// rtl/axil_sram_responder.sv - AXI-Lite subordinate in front of a byte-writable SRAM
module axil_sram_responder
    import axil_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 65536,
    parameter int          LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int         AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    // Unsigned offset compare: addresses below BASE wrap to huge offsets and miss
    function automatic logic in_range(input logic [31:0] a);
        return {1'b0, a - BASE} < LIMIT;
    endfunction

    function automatic logic [AW-1:0] word_index(input logic [31:0] a);
        return AW'((a - BASE) >> 2);
    endfunction

    state_t        state, state_next;
    logic [3:0]    count;
    logic [AW-1:0] index;
    logic          hit;
    logic [31:0]   rdata_reg;
    logic [1:0]    rresp_reg, bresp_reg;
    logic          arready_c, awready_c, wready_c, rvalid_c, bvalid_c;
    logic          ar_take, aw_take, w_take;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_we;
    logic [31:0]   sram_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake readiness; a read request beats a write in IDLE
    always_comb begin
        state_next = state;
        arready_c  = 1'b0;
        awready_c  = 1'b0;
        wready_c   = 1'b0;
        rvalid_c   = 1'b0;
        bvalid_c   = 1'b0;
        case (state)
            IDLE: begin
                arready_c = 1'b1;
                awready_c = !arvalid;
                if (arvalid) begin
                    state_next = R_WAIT;
                end else if (awvalid) begin
                    state_next = W_DATA;
                end
            end
            R_WAIT: if (count == 4'd0) state_next = R_RESP;
            R_RESP: begin
                rvalid_c = 1'b1;
                if (rready) state_next = IDLE;
            end
            W_DATA: begin
                wready_c = 1'b1;
                if (wvalid) state_next = W_WAIT;
            end
            W_WAIT: if (count == 4'd0) state_next = B_RESP;
            B_RESP: begin
                bvalid_c = 1'b1;
                if (bready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign arready = arready_c && !reset;
    assign awready = awready_c && !reset;
    assign wready  = wready_c && !reset;
    assign rvalid  = rvalid_c && !reset;
    assign bvalid  = bvalid_c && !reset;
    assign rdata   = reset ? 32'd0 : rdata_reg;
    assign rresp   = reset ? RESP_OKAY : rresp_reg;
    assign bresp   = reset ? RESP_OKAY : bresp_reg;

    assign ar_take = arready && arvalid;
    assign aw_take = awready && awvalid;
    assign w_take  = wready && wvalid;

    // In IDLE the RAM already reads the incoming read address so LATENCY=0 still has data
    assign sram_addr = (state == IDLE) ? word_index(araddr) : index;
    assign sram_we   = (w_take && hit) ? wstrb : 4'b0000;

    // Address capture, latency countdown and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= 4'd0;
            index     <= '0;
            hit       <= 1'b0;
            rdata_reg <= 32'd0;
            rresp_reg <= RESP_OKAY;
            bresp_reg <= RESP_OKAY;
        end else begin
            if (ar_take) begin
                index <= word_index(araddr);
                hit   <= in_range(araddr);
                count <= LAT;
            end else if (aw_take) begin
                index <= word_index(awaddr);
                hit   <= in_range(awaddr);
            end else if (w_take) begin
                count     <= LAT;
                bresp_reg <= hit ? RESP_OKAY : RESP_SLVERR;
            end else if ((state == R_WAIT || state == W_WAIT) && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (state == R_WAIT && count == 4'd0) begin
                rdata_reg <= hit ? sram_q : 32'd0;
                rresp_reg <= hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    sram_bytewise #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clock (clock),
        .addr  (sram_addr),
        .wdata (wdata),
        .we    (sram_we),
        .rdata (sram_q)
    );

endmodule

// File: tb/tb_axil_sram_responder.sv
// tb/tb_axil_sram_responder.sv - randomized and directed bench for axil_sram_responder
module tb_axil_sram_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 16;
    localparam int          LAT   = 1;

    logic        clock, reset;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    axil_sram_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction-level model: 0 idle, 1 read accepted, 2 write address accepted, 3 write data accepted
    int          phase  = 0;
    int          hs_cyc = 0;
    logic [31:0] w_addr_m;
    logic [31:0] exp_rdata, exp_rmask;
    logic [1:0]  exp_rresp, exp_bresp;
    logic [31:0] mem_m   [DEPTH];
    logic [3:0]  known_m [DEPTH];

    initial for (int i = 0; i < DEPTH; i++) known_m[i] = 4'b0000;

    function automatic bit hit(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2) % DEPTH;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, then advance the model on observed handshakes
    always begin : cmp
        logic e_ar, e_aw, e_w, e_r, e_b;
        int   i;
        @(negedge clock);
        #3;
        cyc++;
        e_ar = !reset && phase == 0;
        e_aw = !reset && phase == 0 && !arvalid;
        e_w  = !reset && phase == 2;
        e_r  = !reset && phase == 1 && cyc >= hs_cyc + LAT + 2;
        e_b  = !reset && phase == 3 && cyc >= hs_cyc + LAT + 2;
        check("arready", 32'(arready), 32'(e_ar));
        check("awready", 32'(awready), 32'(e_aw));
        check("wready", 32'(wready), 32'(e_w));
        check("rvalid", 32'(rvalid), 32'(e_r));
        check("bvalid", 32'(bvalid), 32'(e_b));
        if (reset) begin
            check("reset_rdata", rdata, 32'd0);
            check("reset_rresp", 32'(rresp), 32'd0);
            check("reset_bresp", 32'(bresp), 32'd0);
        end
        if (e_r && rvalid) begin
            check("rdata", rdata & exp_rmask, exp_rdata & exp_rmask);
            check("rresp", 32'(rresp), 32'(exp_rresp));
        end
        if (e_b && bvalid) check("bresp", 32'(bresp), 32'(exp_bresp));
        if (reset) begin
            phase = 0;
        end else begin
            case (phase)
                0: begin
                    if (arvalid && arready) begin
                        if (hit(araddr)) begin
                            i = widx(araddr);
                            exp_rdata = mem_m[i];
                            for (int b = 0; b < 4; b++) exp_rmask[8*b +: 8] = known_m[i][b] ? 8'hFF : 8'h00;
                            exp_rresp = 2'b00;
                        end else begin
                            exp_rdata = 32'd0;
                            exp_rmask = 32'hFFFF_FFFF;
                            exp_rresp = 2'b10;
                        end
                        phase  = 1;
                        hs_cyc = cyc;
                    end else if (awvalid && awready) begin
                        w_addr_m = awaddr;
                        phase    = 2;
                    end
                end
                1: if (rvalid && rready) phase = 0;
                2: if (wvalid && wready) begin
                    if (hit(w_addr_m)) begin
                        i = widx(w_addr_m);
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb[b]) begin
                                mem_m[i][8*b +: 8] = wdata[8*b +: 8];
                                known_m[i][b] = 1'b1;
                            end
                        end
                        exp_bresp = 2'b00;
                    end else begin
                        exp_bresp = 2'b10;
                    end
                    phase  = 3;
                    hs_cyc = cyc;
                end
                3: if (bvalid && bready) phase = 0;
                default: phase = 0;
            endcase
        end
    end

    task automatic do_read(input logic [31:0] addr, input int hold, input bit abort,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int edges, output int done_at);
        int n;
        data = 32'd0; resp = 2'b00; edges = 0; done_at = 0;
        @(negedge clock);
        araddr = addr; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clock); #1; n++; end
        if (n >= 50) begin check("ar_handshake_timeout", 1, 0); arvalid = 1'b0; return; end
        @(negedge clock);
        arvalid = 1'b0;
        if (abort) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            return;
        end
        #1;
        n = 1;
        while (!rvalid && n < 50) begin @(negedge clock); #1; n++; end
        if (n >= 50) begin check("rvalid_timeout", 1, 0); return; end
        edges = n - 1;
        repeat (hold) @(negedge clock);
        rready = 1'b1; data = rdata; resp = rresp; done_at = cyc;
        @(negedge clock);
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int hold, input bit abort,
                            output logic [1:0] resp, output int edges, output int aw_at);
        int n;
        resp = 2'b00; edges = 0; aw_at = 0;
        @(negedge clock);
        awaddr = addr; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clock); #1; n++; end
        if (n >= 50) begin check("aw_handshake_timeout", 1, 0); awvalid = 1'b0; return; end
        aw_at = cyc;
        @(negedge clock);
        awvalid = 1'b0; wdata = data; wstrb = strb; wvalid = 1'b1;
        #1;
        n = 0;
        while (!wready && n < 50) begin @(negedge clock); #1; n++; end
        if (n >= 50) begin check("w_handshake_timeout", 1, 0); wvalid = 1'b0; return; end
        @(negedge clock);
        wvalid = 1'b0;
        if (abort) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            return;
        end
        #1;
        n = 1;
        while (!bvalid && n < 50) begin @(negedge clock); #1; n++; end
        if (n >= 50) begin check("bvalid_timeout", 1, 0); return; end
        edges = n - 1;
        repeat (hold) @(negedge clock);
        bready = 1'b1; resp = bresp;
        @(negedge clock);
        bready = 1'b0;
    endtask

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d1;
        logic [1:0]  r1, r2;
        int          e1, e2, t1, t2, rv_seen;
        logic [31:0] a;
        reset = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        do_write(BASE + 4, 32'hDEAD_BEEF, 4'b1111, 0, 0, r2, e2, t2);
        check("w1_bresp", 32'(r2), 32'd0);
        check("w1_b_edges", 32'(e2), 32'd2);
        do_read(BASE + 4, 0, 0, d1, r1, e1, t1);
        check("r1_rdata", d1, 32'hDEAD_BEEF);
        check("r1_rresp", 32'(r1), 32'd0);
        check("r1_r_edges", 32'(e1), 32'd2);

        do_write(BASE + 4, 32'h0000_00AA, 4'b0001, 1, 0, r2, e2, t2);
        do_read(BASE + 4, 2, 0, d1, r1, e1, t1);
        check("strobe_merge", d1, 32'hDEAD_BEAA);

        fork
            do_read(BASE + 4, 1, 0, d1, r1, e1, t1);
            do_write(BASE + 8, 32'h1234_5678, 4'b1111, 0, 0, r2, e2, t2);
        join
        check("race_read_data", d1, 32'hDEAD_BEAA);
        check("race_write_after_read", 32'(t2 > t1), 32'd1);
        do_read(BASE + 8, 0, 0, d1, r1, e1, t1);
        check("race_write_data", d1, 32'h1234_5678);

        do_write(BASE + 60, 32'h0F0F_0F0F, 4'b1111, 0, 0, r2, e2, t2);
        do_write(BASE - 4, 32'hFFFF_FFFF, 4'b1111, 0, 0, r2, e2, t2);
        check("oor_bresp", 32'(r2), 32'd2);
        do_read(BASE + 60, 0, 0, d1, r1, e1, t1);
        check("oor_no_update", d1, 32'h0F0F_0F0F);
        do_read(BASE + DEPTH * 4, 0, 0, d1, r1, e1, t1);
        check("oor_rresp", 32'(r1), 32'd2);
        check("oor_rdata", d1, 32'd0);

        do_write(BASE + 4, 32'h0000_0000, 4'b0000, 0, 0, r2, e2, t2);
        check("zero_strb_bresp", 32'(r2), 32'd0);
        do_read(BASE + 6, 5, 0, d1, r1, e1, t1);
        check("zero_strb_unchanged", d1, 32'hDEAD_BEAA);

        do_read(BASE + 8, 0, 1, d1, r1, e1, t1);
        #1;
        check("arready_after_reset", 32'(arready), 32'd1);
        rv_seen = 0;
        repeat (6) begin @(negedge clock); #1; if (rvalid) rv_seen++; end
        check("aborted_read_rvalid", 32'(rv_seen), 32'd0);

        do_write(BASE + 12, 32'hCAFE_F00D, 4'b1111, 0, 1, r2, e2, t2);
        do_read(BASE + 12, 0, 0, d1, r1, e1, t1);
        check("aborted_write_kept", d1, 32'hCAFE_F00D);

        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 9))
                0: a = BASE - 32'(4 * $urandom_range(1, 4));
                1: a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 8));
                2: a = $urandom();
                default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 1) == 0)
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 19) == 0, d1, r1, e1, t1);
            else
                do_write(a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 19) == 0, r2, e2, t2);
        end

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
